bullet_pool: RTL and testbench

Parametrised bullet slot pool for the shooter game core: accepts spawn requests via a valid/ready handshake, allocates the lowest-index free slot, and advances every live bullet vertically on a programmable move tick. A bullet retires when it would cross the configured border. Per-slot kill and global clear inputs are provided for collision logic and stage resets. One instance serves player bullets (upward) and another serves enemy bullets (downward); the outputs feed the collision and render blocks.

---
 rtl/bullet_pool.sv | 182 ++++++++++++++++++
 tb/tb_bullet_pool.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_pool.sv
`default_nettype none
// ============================================================================
// Module   : bullet_pool
// Purpose  : Bullet slot pool. Spawn requests use a valid/ready handshake and
//            go to the lowest-index free slot. A programmable move tick steps
//            every live bullet vertically. A bullet retires when its next step
//            would cross the border. Per-slot kill and a global clear are also
//            provided.
// Ports    : i_Clk, i_Rst        clock, asynchronous active-high reset
//            i_fSpawn/i_SpawnPos spawn request and shooter position {x, y}
//            o_fSpawnReady       a slot is free and no clear is in progress
//            i_fKill/i_KillIdx   retire one slot
//            i_fClear            retire all slots, restart the move counter
//            o_BulletState       per-slot live flags
//            o_BulletPosition    slot k at [k*POS_W +: POS_W]
//            o_Count             number of live slots
//            o_DropCnt           saturating count of rejected spawns
// Revision : 1.0  initial release
// ============================================================================
module bullet_pool #(
    parameter int SLOTS    = 16,
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int DIR_DOWN = 1,
    parameter int SPEED    = 1,
    parameter int MOVE_DIV = 4,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 460,
    parameter int SPAWN_DX = 16,
    parameter int SPAWN_DY = 24
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst,
    input  logic                          i_fSpawn,
    input  logic [X_W+Y_W-1:0]            i_SpawnPos,
    output logic                          o_fSpawnReady,
    input  logic                          i_fKill,
    input  logic [$clog2(SLOTS)-1:0]      i_KillIdx,
    input  logic                          i_fClear,
    output logic [SLOTS-1:0]              o_BulletState,
    output logic [SLOTS*(X_W+Y_W)-1:0]    o_BulletPosition,
    output logic [$clog2(SLOTS+1)-1:0]    o_Count,
    output logic [7:0]                    o_DropCnt
);

    localparam int POS_W  = X_W + Y_W;
    localparam int IDX_W  = $clog2(SLOTS);
    localparam int CNT_W  = $clog2(SLOTS + 1);
    localparam int MCNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    // Border arithmetic is done one bit wider than y so y+SPEED cannot wrap.
    localparam logic [Y_W:0]      C_SPEED_EXT = (Y_W+1)'(SPEED);
    localparam logic [Y_W-1:0]    C_SPEED_Y   = Y_W'(SPEED);
    localparam logic [Y_W:0]      C_Y_MAX     = (Y_W+1)'(Y_MAX);
    localparam logic [Y_W:0]      C_Y_LOW     = (Y_W+1)'(Y_MIN + SPEED);
    localparam logic [X_W-1:0]    C_DX        = X_W'(SPAWN_DX);
    localparam logic [Y_W-1:0]    C_DY        = Y_W'(SPAWN_DY);
    localparam logic [MCNT_W-1:0] C_MCNT_LAST = MCNT_W'(MOVE_DIV - 1);

    logic [SLOTS-1:0]            state_q, state_d;
    logic [SLOTS-1:0][POS_W-1:0] pos_q, pos_d;
    logic [MCNT_W-1:0]           mcnt_q, mcnt_d;
    logic [7:0]                  drop_q, drop_d;

    logic                        w_tick;
    logic                        w_ready;
    logic                        w_accept;
    logic [SLOTS-1:0]            w_spawn_sel;
    logic [SLOTS-1:0]            w_kill_sel;
    logic [POS_W-1:0]            w_spawn_pos;

    assign w_tick   = (mcnt_q == C_MCNT_LAST);
    assign w_ready  = ~&state_q & ~i_fClear;
    assign w_accept = i_fSpawn & w_ready;

    // Each field wraps independently.
    assign w_spawn_pos = {i_SpawnPos[POS_W-1:Y_W] + C_DX,
                          i_SpawnPos[Y_W-1:0] + C_DY};

    // Lowest free slot taken from registered state, so a slot freed this
    // cycle is only allocatable on the next one.
    always_comb begin
        logic found;
        found       = 1'b0;
        w_spawn_sel = '0;
        for (int k = 0; k < SLOTS; k++) begin
            if (!state_q[k] && !found) begin
                w_spawn_sel[k] = w_accept;
                found          = 1'b1;
            end
        end
    end

    // A kill aimed at a free slot is ignored. A pending spawn into that slot
    // is then left intact.
    always_comb begin
        w_kill_sel = '0;
        for (int k = 0; k < SLOTS; k++) begin
            w_kill_sel[k] = i_fKill && (i_KillIdx == IDX_W'(k)) && state_q[k];
        end
    end

    // Per-slot priority: clear, kill, spawn, move/retire, hold.
    always_comb begin
        logic [Y_W:0] y_ext;
        logic [Y_W:0] y_down;
        state_d = state_q;
        pos_d   = pos_q;
        y_ext   = '0;
        y_down  = '0;
        for (int k = 0; k < SLOTS; k++) begin
            y_ext  = {1'b0, pos_q[k][Y_W-1:0]};
            y_down = y_ext + C_SPEED_EXT;
            if (i_fClear || w_kill_sel[k]) begin
                state_d[k] = 1'b0;
                pos_d[k]   = '1;
            end else if (w_spawn_sel[k]) begin
                state_d[k] = 1'b1;
                pos_d[k]   = w_spawn_pos;
            end else if (state_q[k] && w_tick) begin
                if (DIR_DOWN != 0) begin
                    if (y_down > C_Y_MAX) begin
                        state_d[k] = 1'b0;
                        pos_d[k]   = '1;
                    end else begin
                        pos_d[k][Y_W-1:0] = y_down[Y_W-1:0];
                    end
                end else begin
                    if (y_ext < C_Y_LOW) begin
                        state_d[k] = 1'b0;
                        pos_d[k]   = '1;
                    end else begin
                        pos_d[k][Y_W-1:0] = pos_q[k][Y_W-1:0] - C_SPEED_Y;
                    end
                end
            end
        end
    end

    always_comb begin
        mcnt_d = mcnt_q + MCNT_W'(1);
        if (i_fClear || w_tick) begin
            mcnt_d = '0;
        end
    end

    // Drops survive a clear; only reset zeroes the count.
    always_comb begin
        drop_d = drop_q;
        if (i_fSpawn && !w_ready && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= '0;
            pos_q   <= '1;
            mcnt_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            mcnt_q  <= mcnt_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        o_Count = '0;
        for (int k = 0; k < SLOTS; k++) begin
            o_Count = o_Count + CNT_W'(state_q[k]);
        end
    end

    assign o_fSpawnReady    = w_ready;
    assign o_BulletState    = state_q;
    assign o_BulletPosition = pos_q;
    assign o_DropCnt        = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_bullet_pool.sv
`default_nettype none
// ============================================================================
// Module   : tb_bullet_pool
// Purpose  : Self-checking bench for bullet_pool. The main instance moves
//            downward. A second instance moves upward and is used for the
//            top-border case.
// Revision : 1.0  initial release
// ============================================================================
module tb_bullet_pool;

    localparam int SLOTS    = 16;
    localparam int POS_W    = 19;
    localparam int MOVE_DIV = 4;
    localparam int SPEED    = 1;
    localparam int Y_MAX    = 460;
    localparam logic [303:0] ALL_ONES = {304{1'b1}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         spawn;
    logic [18:0]  spos;
    logic         kill;
    logic [3:0]   kidx;
    logic         clear;
    logic         ready;
    logic [15:0]  st;
    logic [303:0] bpos;
    logic [4:0]   cnt;
    logic [7:0]   drop;

    logic         u_spawn;
    logic [18:0]  u_pos;
    logic         u_kill;
    logic [3:0]   u_kidx;
    logic         u_clear;
    logic         u_ready;
    logic [15:0]  u_st;
    logic [303:0] u_bpos;
    logic [4:0]   u_cnt;
    logic [7:0]   u_drop;

    bullet_pool #(.SLOTS(16), .X_W(10), .Y_W(9), .DIR_DOWN(1), .SPEED(1),
                  .MOVE_DIV(4), .Y_MIN(0), .Y_MAX(460), .SPAWN_DX(16), .SPAWN_DY(24))
    u_down (
        .i_Clk(clk), .i_Rst(rst), .i_fSpawn(spawn), .i_SpawnPos(spos),
        .o_fSpawnReady(ready), .i_fKill(kill), .i_KillIdx(kidx), .i_fClear(clear),
        .o_BulletState(st), .o_BulletPosition(bpos), .o_Count(cnt), .o_DropCnt(drop)
    );

    bullet_pool #(.SLOTS(16), .X_W(10), .Y_W(9), .DIR_DOWN(0), .SPEED(1),
                  .MOVE_DIV(4), .Y_MIN(0), .Y_MAX(460), .SPAWN_DX(16), .SPAWN_DY(24))
    u_up (
        .i_Clk(clk), .i_Rst(rst), .i_fSpawn(u_spawn), .i_SpawnPos(u_pos),
        .o_fSpawnReady(u_ready), .i_fKill(u_kill), .i_KillIdx(u_kidx), .i_fClear(u_clear),
        .o_BulletState(u_st), .o_BulletPosition(u_bpos), .o_Count(u_cnt), .o_DropCnt(u_drop)
    );

    // ---------------- reference model of the downward pool ----------------
    logic [15:0] m_state;
    logic [18:0] m_pos [SLOTS];
    int          m_mcnt;
    int          m_drop;

    typedef struct {
        logic [15:0]  st;
        logic [303:0] pos;
        logic [4:0]   cnt;
        logic [7:0]   drop;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic       sp;
        logic [9:0] x;
        logic [8:0] y;
        logic [4:0] cnt;
        logic [8:0] y0;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [303:0] act, input logic [303:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [18:0] slot_of(input logic [303:0] b, input int k);
        return b[k*POS_W +: POS_W];
    endfunction

    task automatic model_reset();
        m_state = '0;
        for (int k = 0; k < SLOTS; k++) m_pos[k] = '1;
        m_mcnt = 0;
        m_drop = 0;
    endtask

    task automatic model_edge(input logic sp, input logic [18:0] p, input logic kl,
                              input logic [3:0] ki, input logic cl);
        logic        rdy;
        logic        tick;
        int          free;
        int          y;
        logic [15:0] ns;
        logic [18:0] np [SLOTS];
        rdy  = (m_state != 16'hFFFF) && !cl;
        tick = (m_mcnt == MOVE_DIV - 1);
        free = -1;
        for (int k = SLOTS - 1; k >= 0; k--) if (!m_state[k]) free = k;
        ns = m_state;
        np = m_pos;
        for (int k = 0; k < SLOTS; k++) begin
            if (cl || (kl && ki == k && m_state[k])) begin
                ns[k] = 1'b0;
                np[k] = '1;
            end else if (sp && rdy && free == k) begin
                ns[k] = 1'b1;
                np[k] = {p[18:9] + 10'd16, p[8:0] + 9'd24};
            end else if (m_state[k] && tick) begin
                y = int'(m_pos[k][8:0]);
                if (y + SPEED > Y_MAX) begin
                    ns[k] = 1'b0;
                    np[k] = '1;
                end else begin
                    np[k][8:0] = 9'(y + SPEED);
                end
            end
        end
        if (sp && !rdy && m_drop < 255) m_drop++;
        m_mcnt  = (cl || tick) ? 0 : m_mcnt + 1;
        m_state = ns;
        m_pos   = np;
    endtask

    // Drive one cycle, push the model's prediction, compare after the edge.
    task automatic step(input logic sp, input logic [18:0] p, input logic kl,
                        input logic [3:0] ki, input logic cl);
        exp_t e;
        spawn = sp; spos = p; kill = kl; kidx = ki; clear = cl;
        #1;
        chk("ready", ready, (m_state != 16'hFFFF) && !cl);
        model_edge(sp, p, kl, ki, cl);
        e.st = m_state;
        for (int k = 0; k < SLOTS; k++) e.pos[k*POS_W +: POS_W] = m_pos[k];
        e.cnt  = 5'($countones(m_state));
        e.drop = 8'(m_drop);
        sb.push_back(e);
        @(posedge clk);
        #1;
        spawn = 1'b0; kill = 1'b0; clear = 1'b0;
        e = sb.pop_front();
        chk("state", st, e.st);
        chk("position", bpos, e.pos);
        chk("count", cnt, e.cnt);
        chk("dropcnt", drop, e.drop);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vt [9];

    initial begin
        vt[0] = '{1'b1, 10'd100, 9'd50, 5'd1, 9'd74};
        vt[1] = '{1'b0, 10'd0,   9'd0,  5'd1, 9'd74};
        vt[2] = '{1'b0, 10'd0,   9'd0,  5'd1, 9'd74};
        vt[3] = '{1'b0, 10'd0,   9'd0,  5'd1, 9'd75};
        vt[4] = '{1'b0, 10'd0,   9'd0,  5'd1, 9'd75};
        vt[5] = '{1'b0, 10'd0,   9'd0,  5'd1, 9'd75};
        vt[6] = '{1'b0, 10'd0,   9'd0,  5'd1, 9'd75};
        vt[7] = '{1'b0, 10'd0,   9'd0,  5'd1, 9'd76};
        vt[8] = '{1'b1, 10'd0,   9'd0,  5'd2, 9'd76};

        rst = 1'b1; spawn = 0; spos = 0; kill = 0; kidx = 0; clear = 0;
        u_spawn = 0; u_pos = 0; u_kill = 0; u_kidx = 0; u_clear = 0;
        model_reset();
        #12;
        chk("reset state", st, 16'h0);
        chk("reset position", bpos, ALL_ONES);
        chk("reset count", cnt, 5'd0);
        chk("reset dropcnt", drop, 8'd0);
        chk("reset ready", ready, 1'b1);
        rst = 1'b0;

        // Spawn {100,50}, then watch it step every fourth edge.
        for (int i = 0; i < 9; i++) begin
            step(vt[i].sp, {vt[i].x, vt[i].y}, 1'b0, '0, 1'b0);
            chk("table count", cnt, vt[i].cnt);
            chk("table y0", slot_of(bpos, 0), {10'd116, vt[i].y0});
        end

        // Lower border: y=459 -> 460 on first tick -> retired on second.
        step(1'b0, '0, 1'b0, '0, 1'b1);
        step(1'b1, {10'd0, 9'd435}, 1'b0, '0, 1'b0);
        chk("border spawn y", slot_of(bpos, 0), {10'd16, 9'd459});
        idle(); idle(); idle();
        chk("border first tick", slot_of(bpos, 0), {10'd16, 9'd460});
        idle(); idle(); idle(); idle();
        chk("border retire state", st[0], 1'b0);
        chk("border retire pos", slot_of(bpos, 0), 19'h7FFFF);

        // Fill all 16 slots, then one drop.
        for (int i = 0; i < 17; i++) begin
            step(1'b1, '0, 1'b0, '0, 1'b0);
            if (i < 16) chk("fill order", st, 16'((32'd1 << (i + 1)) - 1));
        end
        chk("full ready", ready, 1'b0);
        chk("first drop", drop, 8'd1);

        // Kill slot 3, respawn lands in slot 3.
        step(1'b0, '0, 1'b1, 4'd3, 1'b0);
        chk("kill3 state", st[3], 1'b0);
        chk("kill3 ready", ready, 1'b1);
        step(1'b1, '0, 1'b0, '0, 1'b0);
        chk("respawn slot3", slot_of(bpos, 3), {10'd16, 9'd24});
        chk("respawn full", st, 16'hFFFF);

        // Kill on a tick edge retires slot 5 unmoved.
        while (m_mcnt != MOVE_DIV - 1) idle();
        step(1'b0, '0, 1'b1, 4'd5, 1'b0);
        chk("kill on tick state", st[5], 1'b0);
        chk("kill on tick pos", slot_of(bpos, 5), 19'h7FFFF);
        // Spawn on a tick edge is not moved.
        while (m_mcnt != MOVE_DIV - 1) idle();
        step(1'b1, {10'd200, 9'd100}, 1'b0, '0, 1'b0);
        chk("spawn on tick pos", slot_of(bpos, 5), {10'd216, 9'd124});

        // Clear together with spawn: nothing accepted, drop counted.
        step(1'b1, {10'd1, 9'd1}, 1'b0, '0, 1'b1);
        chk("clear state", st, 16'h0);
        chk("clear count", cnt, 5'd0);
        chk("clear drop", drop, 8'd2);

        // Upward instance: spawn wraps to y=0 and retires on the first tick.
        u_clear = 1'b1;
        idle();
        u_clear = 1'b0; u_spawn = 1'b1; u_pos = {10'd100, 9'd488};
        idle();
        u_spawn = 1'b0;
        chk("up spawn pos", slot_of(u_bpos, 0), {10'd116, 9'd0});
        idle(); idle();
        chk("up live before tick", u_st[0], 1'b1);
        idle();
        chk("up retire state", u_st[0], 1'b0);
        chk("up retire pos", slot_of(u_bpos, 0), 19'h7FFFF);

        // Saturate the drop counter.
        for (int i = 0; i < 316; i++) step(1'b1, '0, 1'b0, '0, 1'b0);
        chk("drop saturate", drop, 8'd255);
        chk("saturate full", st, 16'hFFFF);

        // Asynchronous reset with 8 live slots and move counter at 2.
        step(1'b0, '0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, {10'd100, 9'd50}, 1'b0, '0, 1'b0);
        idle(); idle();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("async state", st, 16'h0);
        chk("async position", bpos, ALL_ONES);
        chk("async count", cnt, 5'd0);
        chk("async dropcnt", drop, 8'd0);
        #3 rst = 1'b0;
        step(1'b1, {10'd100, 9'd50}, 1'b0, '0, 1'b0);
        chk("post reset spawn", slot_of(bpos, 0), {10'd116, 9'd74});
        idle(); idle();
        chk("post reset no early tick", slot_of(bpos, 0), {10'd116, 9'd74});
        idle();
        chk("post reset tick 4th edge", slot_of(bpos, 0), {10'd116, 9'd75});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
